// File: rtl/buffer_circ_pkg.sv
// Shared types and defaults for the buffer_circ write-side arbiter.
// Owner index width helper keeps a 1-bit minimum so two producers still get a port.
package buffer_circ_pkg;

  localparam int SIZE_DEF      = 16;
  localparam int PAR_WRITE_DEF = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  function automatic int owner_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/buffer_circ_rr_pick.sv
// Combinational round-robin picker: first requester after last_owner, with wrap.
// Zero latency; no backpressure, the caller decides when the pick is taken.
module buffer_circ_rr_pick
  import buffer_circ_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OW      = owner_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OW-1:0]      last_owner,
  output logic               valid,
  output logic [OW-1:0]      pick
);

  int          idx;
  logic [OW-1:0] idx_w;

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    valid = 1'b0;
    pick  = '0;
    idx   = 0;
    idx_w = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx   = (int'(last_owner) + off) % NUM_REQ;
      idx_w = OW'(idx);
      if (req[idx_w]) begin
        valid = 1'b1;
        pick  = idx_w;
      end
    end
  end

endmodule

// File: rtl/buffer_circ_wr_arb.sv
// Round-robin packet arbiter sharing one buffer_circ write port; one idle bubble per grant,
// writes are combinational from accept; stalls indefinitely on buf_ready=0 or buf_full=1.
module buffer_circ_wr_arb
  import buffer_circ_pkg::*;
#(
  parameter int SIZE      = SIZE_DEF,
  parameter int PAR_WRITE = PAR_WRITE_DEF,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8,
  localparam int OW       = owner_w(NUM_REQ),
  localparam int BW       = PAR_WRITE * SIZE,
  localparam int CW       = $clog2(MAX_BURST) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    last,
  input  logic [NUM_REQ*BW-1:0] din,
  output logic [NUM_REQ-1:0]    gnt,
  input  logic                  buf_ready,
  input  logic                  buf_full,
  output logic                  buf_wen,
  output logic [BW-1:0]         buf_din,
  output logic [OW-1:0]         owner,
  output logic                  busy
);

  arb_state_t    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_owner_q, last_owner_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic          pick_vld;
  logic [OW-1:0] pick;
  logic          in_burst;
  logic          accept;
  logic          cap_hit;

  buffer_circ_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OW      (OW)
  ) u_rr_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .valid      (pick_vld),
    .pick       (pick)
  );

  // Outputs are gated by rst so nothing reaches the buffer during a reset cycle.
  assign in_burst = rst && (state_q == ARB_BURST);
  assign accept   = in_burst && req[owner_q] && buf_ready && !buf_full;
  assign cap_hit  = (beat_cnt_q == CW'(MAX_BURST - 1));

  assign gnt     = accept ? (NUM_REQ'(1) << owner_q) : '0;
  assign buf_wen = accept;
  assign buf_din = accept ? din[owner_q*BW +: BW] : '0;
  assign owner   = owner_q;
  assign busy    = in_burst;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          state_d      = ARB_BURST;
          owner_d      = pick;
          last_owner_d = pick;
          beat_cnt_d   = '0;
        end
      end
      ARB_BURST: begin
        // A dropped request ends the packet without writing anything this cycle.
        if (!req[owner_q]) begin
          state_d = ARB_IDLE;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (last[owner_q] || cap_hit) begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_buffer_circ_wr_arb.sv
// Directed plan steps plus randomized packet traffic against a transaction-level model.
// Inputs are driven and outputs checked just after each falling edge.
module tb_buffer_circ_wr_arb;

  localparam int NR = 4;

  logic          clk;
  logic          rst;
  logic [3:0]    req;
  logic [3:0]    last;
  logic [255:0]  din;
  logic [3:0]    gnt;
  logic          buf_ready;
  logic          buf_full;
  logic          buf_wen;
  logic [63:0]   buf_din;
  logic [1:0]    owner;
  logic          busy;

  logic [63:0]   slice [NR];
  logic [63:0]   spk [3];
  int            pc [NR];
  bit            spec_mode;
  int            n_cmp;
  int            n_err;

  logic [64:0]   pq [NR][$];
  logic [64:0]   mq [NR][$];
  logic [65:0]   expq [$];
  logic [65:0]   e;
  logic [64:0]   b;
  int            p;
  int            ptr;
  int            nb;
  int            cycles;

  buffer_circ_wr_arb #(
    .SIZE      (16),
    .PAR_WRITE (4),
    .NUM_REQ   (4),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .din       (din),
    .gnt       (gnt),
    .buf_ready (buf_ready),
    .buf_full  (buf_full),
    .buf_wen   (buf_wen),
    .buf_din   (buf_din),
    .owner     (owner),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    din = '0;
    for (int i = 0; i < NR; i++) din[i*64 +: 64] = slice[i];
  end

  function automatic logic [63:0] bval(input int i, input int n);
    int base;
    base = i * 256 + n * 4;
    return {16'(base + 3), 16'(base + 2), 16'(base + 1), 16'(base)};
  endfunction

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r_n, input logic [3:0] r, input logic [3:0] l,
                      input logic rdy, input logic full, input logic [3:0] eg,
                      input logic eb, input int eo, input string tag);
    logic [63:0] exp_din;
    @(negedge clk);
    rst = r_n; req = r; last = l; buf_ready = rdy; buf_full = full;
    for (int i = 0; i < NR; i++) slice[i] = bval(i, pc[i]);
    if (spec_mode) slice[1] = spk[(pc[1] < 3) ? pc[1] : 2];
    #1;
    exp_din = (eg == 4'b0) ? 64'h0 : slice[oh2i(eg)];
    chk({tag, "_gnt"}, 64'(gnt), 64'(eg));
    chk({tag, "_wen"}, 64'(buf_wen), 64'(|eg));
    chk({tag, "_din"}, buf_din, exp_din);
    chk({tag, "_busy"}, 64'(busy), 64'(eb));
    if (eo >= 0) chk({tag, "_owner"}, 64'(owner), 64'(eo));
    if (eg != 4'b0) pc[oh2i(eg)]++;
  endtask

  task automatic do_reset();
    for (int i = 0; i < NR; i++) pc[i] = 0;
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, -1, "rst_seq");
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, -1, "rst_seq");
  endtask

  initial begin
    n_cmp = 0; n_err = 0; spec_mode = 0;
    rst = 1'b0; req = '0; last = '0; buf_ready = 1'b1; buf_full = 1'b0;
    for (int i = 0; i < NR; i++) begin slice[i] = '0; pc[i] = 0; end
    spk[0] = {16'd1, 16'd2, 16'd3, 16'd4};
    spk[1] = {16'd8, 16'd7, 16'd6, 16'd5};
    spk[2] = {16'd10, 16'd14, 16'd16, 16'd19};

    // Reset with every producer requesting, then first grant after one bubble.
    step(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, -1, "reset");
    step(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, -1, "reset");
    step(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, -1, "rst_bubble");
    step(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 0, "rst_first");

    // Single three-beat packet on producer 1.
    do_reset();
    spec_mode = 1;
    step(1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, -1, "sp_bubble");
    step(1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0010, 1'b1, 1, "sp_b0");
    step(1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0010, 1'b1, 1, "sp_b1");
    step(1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 1, "sp_b2");
    step(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, -1, "sp_idle");
    spec_mode = 0;

    // Fairness between producers 0 and 2, single-beat packets.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 4'b0101, 4'b0101, 1'b1, 1'b0,
           (k % 2 == 0) ? 4'b0000 : ((k % 4 == 1) ? 4'b0001 : 4'b0100),
           1'(k % 2), (k % 2 == 0) ? -1 : ((k % 4 == 1) ? 0 : 2), "fair");
    end
    step(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, -1, "fair_end");

    // Backpressure: two not-ready cycles, then a full-only cycle.
    do_reset();
    step(1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, -1, "bp_bubble");
    step(1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0100, 1'b1, 2, "bp_b0");
    step(1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2, "bp_stall1");
    step(1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2, "bp_stall2");
    step(1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0100, 1'b1, 2, "bp_b1");
    step(1'b1, 4'b0100, 4'b0100, 1'b1, 1'b1, 4'b0000, 1'b1, 2, "bp_full");
    step(1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 2, "bp_b2");
    step(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, -1, "bp_idle");

    // Burst cap: producer 3 six beats, producer 0 waiting with one beat.
    do_reset();
    step(1'b1, 4'b1000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, -1, "cap_bubble");
    for (int k = 0; k < 4; k++)
      step(1'b1, 4'b1001, 4'b0001, 1'b1, 1'b0, 4'b1000, 1'b1, 3, "cap_p3");
    step(1'b1, 4'b1001, 4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, -1, "cap_rel");
    step(1'b1, 4'b1001, 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 0, "cap_p0");
    step(1'b1, 4'b1000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, -1, "cap_bubble2");
    step(1'b1, 4'b1000, 4'b0000, 1'b1, 1'b0, 4'b1000, 1'b1, 3, "cap_p3_rest");
    step(1'b1, 4'b1000, 4'b1000, 1'b1, 1'b0, 4'b1000, 1'b1, 3, "cap_p3_last");
    step(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, -1, "cap_idle");

    // Reset in the middle of a burst.
    do_reset();
    step(1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, -1, "mr_bubble");
    step(1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0010, 1'b1, 1, "mr_b0");
    step(1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, -1, "mr_rst");
    step(1'b1, 4'b0011, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, -1, "mr_bubble2");
    step(1'b1, 4'b0011, 4'b0000, 1'b1, 1'b0, 4'b0001, 1'b1, 0, "mr_p0");

    // Abandonment: owner drops req without last.
    do_reset();
    step(1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, -1, "ab_bubble");
    step(1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0100, 1'b1, 2, "ab_b0");
    step(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2, "ab_drop");
    step(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, -1, "ab_idle");

    // Randomized traffic: all packets queued up front, random backpressure.
    for (int run = 0; run < 3; run++) begin
      do_reset();
      expq.delete();
      for (int i = 0; i < NR; i++) begin
        pq[i].delete();
        mq[i].delete();
        for (int k = 0; k < int'($urandom_range(3)); k++) begin
          nb = int'($urandom_range(6, 1));
          for (int j = 0; j < nb; j++) begin
            b = {1'(j == nb - 1), $urandom, $urandom};
            pq[i].push_back(b);
            mq[i].push_back(b);
          end
        end
      end
      // Expected write order: round-robin sessions of up to four beats, ending on last.
      ptr = NR - 1;
      while (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() != 0) begin
        p = -1;
        for (int off = 1; off <= NR; off++)
          if (p < 0 && mq[(ptr + off) % NR].size() != 0) p = (ptr + off) % NR;
        ptr = p;
        nb = 0;
        do begin
          b = mq[p].pop_front();
          expq.push_back({2'(p), b[63:0]});
          nb++;
        end while (!b[64] && nb < 4 && mq[p].size() != 0);
      end
      cycles = 0;
      while (expq.size() != 0 && cycles < 3000) begin
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NR; i++) begin
          req[i]   = (pq[i].size() != 0);
          slice[i] = (pq[i].size() != 0) ? pq[i][0][63:0] : 64'h0;
          last[i]  = (pq[i].size() != 0) ? pq[i][0][64] : 1'b0;
        end
        buf_ready = ($urandom_range(3) != 0);
        buf_full  = ($urandom_range(4) == 0);
        #1;
        chk("rnd_onehot", 64'($onehot0(gnt)), 64'd1);
        chk("rnd_wen", 64'(buf_wen), 64'(|gnt));
        if (!buf_ready || buf_full) chk("rnd_blocked", 64'(buf_wen), 64'd0);
        if (buf_wen) begin
          p = oh2i(gnt);
          e = expq.pop_front();
          chk("rnd_prod", 64'(p), 64'(e[65:64]));
          chk("rnd_data", buf_din, e[63:0]);
          if (pq[p].size() != 0) void'(pq[p].pop_front());
        end
        cycles++;
      end
      chk("rnd_drained", 64'(expq.size()), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/buffer_circ_wr_arb.md
Name: buffer_circ_wr_arb

Overview:
Round-robin write arbiter that shares one buffer_circ write port between NUM_REQ producers. Each producer offers packets of PAR_WRITE-word beats. The arbiter locks onto one producer for a whole packet, capped at MAX_BURST beats, and drives buffer_circ wen/din directly. It honours the buffer's ready/full flow control. It sits between the producer datapaths and buffer_circ; the read side is untouched.

Parameters:
SIZE, 16, width of one buffer word
PAR_WRITE, 4, words per beat (must equal buffer_circ PAR_WRITE)
NUM_REQ, 4, number of producers (2..16)
MAX_BURST, 8, maximum beats per grant before forced release (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
req  in  NUM_REQ  producer i has a beat on din slice i
last  in  NUM_REQ  beat from producer i is its packet's final beat
din  in  NUM_REQ*PAR_WRITE*SIZE  slice i = producer i beat, same word order as buffer_circ din
gnt  out  NUM_REQ  one-hot; beat of producer i accepted this cycle
buf_ready  in  1  buffer_circ ready: room for one PAR_WRITE beat
buf_full  in  1  buffer_circ full
buf_wen  out  1  to buffer_circ wen
buf_din  out  PAR_WRITE*SIZE  to buffer_circ din
owner  out  clog2(NUM_REQ)  index of producer currently locked
busy  out  1  high while in ARB_BURST

Behaviour:
- Reset (rst=0 at a rising edge): state=ARB_IDLE, owner=0, beat_cnt=0, last_owner=NUM_REQ-1. Outputs while in reset: gnt=0, buf_wen=0, buf_din=0, busy=0.
- Reset asserted mid-burst: same as above. Beats already written stay in the buffer; there is no rollback.
- FSM has two states:
  - ARB_IDLE: gnt=0, buf_wen=0. If any req is high, rr_pick selects the first requester searching from (last_owner+1) mod NUM_REQ upward with wrap. Next cycle: owner=pick, last_owner=pick, beat_cnt=0, state=ARB_BURST. This is a one-cycle arbitration bubble.
  - ARB_BURST: accept = req[owner] & buf_ready & ~buf_full. gnt[owner]=accept; all other gnt bits are 0. buf_wen=accept. buf_din = din slice owner when accept, else 0. Both are combinational, so there is zero latency from accept to write.
- On accept: beat_cnt++. Release (go to ARB_IDLE next cycle) if last[owner]=1 or beat_cnt==MAX_BURST-1.
- req[owner]=0 in ARB_BURST: release to ARB_IDLE next cycle; this is treated as end of packet. No beat is written that cycle.
- Backpressure (buf_ready=0 or buf_full=1): gnt=0, buf_wen=0. beat_cnt, owner and state hold. Stall length is unbounded.
- buf_full=1 with buf_ready=1 is treated as not-ready, so no write ever occurs on full.
- A forced release after MAX_BURST beats moves the round-robin pointer past the owner. An unfinished packet resumes on that producer's next grant.
- Requests arriving in ARB_BURST from non-owners are held off, with no grant, until release.
- beat_cnt width is clog2(MAX_BURST)+1; it never wraps.
- Producers must hold din/last stable while req=1 and gnt=0.

Decomposition:
- Package buffer_circ_pkg: default SIZE/PAR_WRITE constants, arb_state_t enum {ARB_IDLE, ARB_BURST}, and a function for the owner index width.
- One sub-module, buffer_circ_rr_pick: combinational round-robin picker with inputs req and last_owner, outputs valid and pick index.
- The FSM, counters and datapath mux stay in the top module.

Test Plan:
(NUM_REQ=4, PAR_WRITE=4, SIZE=16, MAX_BURST=4; buf_ready=1 and buf_full=0 unless stated.)
- Reset: rst=0 for 2 cycles with req=4'b1111 -> gnt=0, buf_wen=0, buf_din=0, busy=0. First grant after rst=1 goes to producer 0 after one bubble cycle.
- Single packet: req[1] with beats {4,3,2,1}, {5,6,7,8}, {19,16,14,10}, last on the third beat -> busy=1, owner=1 from cycle t+1. gnt=4'b0010 and buf_din equals each beat in t+1..t+3. ARB_IDLE at t+4.
- Fairness: req[0] and req[2] held high, every beat last=1 -> owner sequence 0,2,0,2. One write every 2 cycles, never two consecutive grants to the same producer.
- Backpressure: buf_ready=0 for 2 cycles during beat 2 of a 3-beat packet -> gnt=0 and buf_wen=0 for those cycles, owner unchanged. Beat 2 is written on the first cycle buf_ready=1; buf_full=1 alone also blocks.
- Burst cap: req[3] 6-beat packet with req[0] pending -> 4 beats from producer 3, release, then producer 0's packet, then the remaining 2 beats from producer 3.
- Mid-burst reset and abandonment: rst=0 after beat 1 -> outputs 0, next grant goes to producer 0. Separately, dropping req[owner] without last -> ARB_IDLE the next cycle with no extra write.
